pmp_fault_unit: RTL and testbench
=================================

# pmp_fault_unit

PMP fault capture and halt controller that sits between the instruction/data PMP checkers and the core's PC/debug logic. It consumes the `instr_exec_violation`, `data_read_violation` and `data_write_violation` flags. Each new violation episode becomes a fault record (cause, PC, data address), which is queued for a debug/trap reader over a valid/ready pop interface. An execute violation raises a PC-freeze request that holds until an explicit resume.

## Interface
- `DEPTH`, 4: fault-record FIFO entries (power of two, ≥2).
- `CNT_W`, 8: width of each saturating violation counter.
- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `PC_In`  in  8  current PC of the instruction being checked.
- `Data_Addr`  in  8  address of the current data access.
- `instr_exec_violation`, `data_read_violation`, `data_write_violation`  in  1 each  raw checker flags (level, may persist across cycles).
- `Resume`  in  1  single-cycle pulse: leave HALTED.
- `Clear_Counts`  in  1  single-cycle pulse: zero all counters and `Overflow`.
- `Halt_Req`  out  1  PC freeze request to the core.
- `rd_valid`  out  1  FIFO head is valid.
- `rd_ready`  in  1  reader accepts head.
- `rd_cause`  out  2  head cause code.
- `rd_pc`  out  8  head PC.
- `rd_addr`  out  8  head data address.
- `exec_count`, `read_count`, `write_count`  out  CNT_W each  episode counters.
- `Overflow`  out  1  sticky: a record was dropped because the FIFO was full.

## Operation
- Cause codes: EXEC = 2'b01, READ = 2'b10, WRITE = 2'b11.
- Episode detection: per flag, a registered previous value. An event is a rising edge (flag = 1, previous = 0). A flag held high counts once and re-arms only after it deasserts.
- Priority per cycle: EXEC > READ > WRITE. At most one event is accepted per cycle. Lower-priority simultaneous events are discarded (not counted, not recorded).
- FSM states:
  - RUN: an accepted event increments its counter (saturating at all-ones) and pushes a record {cause, `PC_In`, `Data_Addr`}. For EXEC, `rd_addr` is 8'h00. An EXEC event moves the FSM to HALTED.
  - HALTED: all violation events are ignored (no counts, no pushes); edge registers still track the flags. A `Resume` pulse moves the FSM to RUN.
- `Halt_Req` = (state == HALTED) | (state == RUN & EXEC event). The freeze therefore applies in the same cycle as the violation.
- FIFO full on push: the record is dropped, the counter still increments, and `Overflow` is set. For EXEC, the transition to HALTED still occurs.
- Pop: `rd_valid & rd_ready` at a clock edge removes the head. A simultaneous push and pop on a full FIFO succeeds with no overflow.
- `Clear_Counts` has priority over an increment in the same cycle; the result is 0. The pulse does not affect the FIFO or the FSM.
- `Resume` together with a new EXEC event in the same cycle: the FSM stays HALTED and the event is recorded and counted. Resume is consumed.

## Timing
- Reset values (async on `Reset` = 0): state RUN, FIFO empty, `rd_valid` 0, `rd_cause`/`rd_pc`/`rd_addr` 0, all counters 0, `Overflow` 0, edge registers 0, `Halt_Req` 0.
- Reset mid-HALTED or with a full FIFO clears everything immediately. `Halt_Req` drops without a clock.
- Event sampled at edge N:
  - counter updated and visible after edge N;
  - `rd_valid` high after edge N if the FIFO was empty (1-cycle push latency);
  - `Halt_Req` is combinational in cycle N and registered-high from edge N onward.
- `rd_*` are registered from FIFO storage and stable while `rd_valid & !rd_ready`.
- Back-to-back episodes need a deasserted flag for at least one sampled cycle between them.

## Structure
- Package `pmp_fault_pkg`: cause-code constants, FSM state enum (RUN, HALTED), record width constant (18) and record field offsets.
- Sub-module `pmp_fault_fifo`: synchronous FIFO parameterised by depth and width. It provides push/full and pop/valid/ready, and flags full-on-push. Pointers carry an extra wrap bit.
- Top contains edge detection, the priority encoder, the FSM, the counters and the `Halt_Req` logic.

## Test plan
- `data_read_violation` high for 3 cycles at PC 0x10, addr 0x80 → `read_count` = 1; one record {2'b10, 0x10, 0x80}; `Halt_Req` stays 0.
- Read episode, then `instr_exec_violation` at PC 0x24 → `Halt_Req` = 1 in the same cycle and held; `exec_count` = 1; two records in order. A later `data_write_violation` leaves `write_count` = 0 and the FIFO unchanged.
- Exec and read asserted in the same cycle at PC 0x30 → only the EXEC record; `read_count` = 0; HALTED.
- Five read episodes with `rd_ready` = 0 and `DEPTH` = 4 → four records, `read_count` = 5, `Overflow` = 1. Draining yields the first four in order.
- In HALTED, pulse `Resume`, then a new exec at PC 0x40 → `Halt_Req` drops for one cycle, then re-asserts; `exec_count` = 2. Pulse `Clear_Counts` → all counters 0 and `Overflow` 0.
- Assert `Reset` = 0 asynchronously mid-HALTED with 2 queued records → `Halt_Req` and `rd_valid` become 0 immediately; counters are 0.

Source files
------------

// File: rtl/pmp_fault_pkg.sv
// Shared definitions for the PMP fault capture unit: cause codes, FSM states
// and the layout of a queued fault record.
package pmp_fault_pkg;

    localparam logic [1:0] CAUSE_EXEC  = 2'b01;
    localparam logic [1:0] CAUSE_READ  = 2'b10;
    localparam logic [1:0] CAUSE_WRITE = 2'b11;

    typedef enum logic {
        RUN,
        HALTED
    } fault_state_t;

    // Record layout is {cause, pc, addr}, addr in the low byte.
    localparam int REC_W         = 18;
    localparam int REC_ADDR_LSB  = 0;
    localparam int REC_PC_LSB    = 8;
    localparam int REC_CAUSE_LSB = 16;

    function automatic logic [REC_W-1:0] pack_record(input logic [1:0] cause,
                                                     input logic [7:0] pc,
                                                     input logic [7:0] addr);
        return {cause, pc, addr};
    endfunction

endpackage

// File: rtl/pmp_fault_fifo.sv
// Small synchronous FIFO for fault records; pointers carry a wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module pmp_fault_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             drop,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop;
    logic             push_ok;

    assign valid = (wr_ptr != rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop   = valid & ready;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/pmp_fault_unit.sv
// PMP fault capture and halt controller: turns checker flag episodes into
// counted, queued fault records and freezes the PC on execute violations.
module pmp_fault_unit
    import pmp_fault_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [7:0]       PC_In,
    input  logic [7:0]       Data_Addr,
    input  logic             instr_exec_violation,
    input  logic             data_read_violation,
    input  logic             data_write_violation,
    input  logic             Resume,
    input  logic             Clear_Counts,
    output logic             Halt_Req,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [1:0]       rd_cause,
    output logic [7:0]       rd_pc,
    output logic [7:0]       rd_addr,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] read_count,
    output logic [CNT_W-1:0] write_count,
    output logic             Overflow
);

    fault_state_t state, next_state;

    logic             exec_prev, read_prev, write_prev;
    logic             ev_exec, ev_read, ev_write;
    logic             acc_exec, acc_read, acc_write;
    logic             push;
    logic [1:0]       push_cause;
    logic [7:0]       push_addr;
    logic             fifo_full;
    logic             fifo_drop;
    logic [REC_W-1:0] head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign ev_exec  = instr_exec_violation & ~exec_prev;
    assign ev_read  = data_read_violation  & ~read_prev;
    assign ev_write = data_write_violation & ~write_prev;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            exec_prev  <= 1'b0;
            read_prev  <= 1'b0;
            write_prev <= 1'b0;
            state      <= RUN;
        end else begin
            exec_prev  <= instr_exec_violation;
            read_prev  <= data_read_violation;
            write_prev <= data_write_violation;
            state      <= next_state;
        end
    end

    // Only one event per cycle survives; HALTED accepts an exec only when it
    // coincides with Resume, which then keeps the core frozen.
    always_comb begin
        next_state = state;
        acc_exec   = 1'b0;
        acc_read   = 1'b0;
        acc_write  = 1'b0;
        case (state)
            RUN: begin
                if (ev_exec) begin
                    acc_exec   = 1'b1;
                    next_state = HALTED;
                end else if (ev_read) begin
                    acc_read = 1'b1;
                end else if (ev_write) begin
                    acc_write = 1'b1;
                end
            end
            HALTED: begin
                if (Resume) begin
                    if (ev_exec) begin
                        acc_exec = 1'b1;
                    end else begin
                        next_state = RUN;
                    end
                end
            end
            default: next_state = RUN;
        endcase
    end

    assign Halt_Req   = (state == HALTED) | ((state == RUN) & ev_exec);
    assign push       = acc_exec | acc_read | acc_write;
    assign push_cause = acc_exec ? CAUSE_EXEC : (acc_read ? CAUSE_READ : CAUSE_WRITE);
    assign push_addr  = acc_exec ? 8'h00 : Data_Addr;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            exec_count  <= '0;
            read_count  <= '0;
            write_count <= '0;
            Overflow    <= 1'b0;
        end else if (Clear_Counts) begin
            exec_count  <= '0;
            read_count  <= '0;
            write_count <= '0;
            Overflow    <= 1'b0;
        end else begin
            if (acc_exec)  exec_count  <= sat_inc(exec_count);
            if (acc_read)  read_count  <= sat_inc(read_count);
            if (acc_write) write_count <= sat_inc(write_count);
            if (fifo_drop) Overflow    <= 1'b1;
        end
    end

    pmp_fault_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(REC_W)
    ) u_fifo (
        .clk       (Clock),
        .rst_n     (Reset),
        .push      (push),
        .push_data (pack_record(push_cause, PC_In, push_addr)),
        .full      (fifo_full),
        .drop      (fifo_drop),
        .valid     (rd_valid),
        .ready     (rd_ready),
        .head      (head)
    );

    assign rd_cause = head[REC_CAUSE_LSB +: 2];
    assign rd_pc    = head[REC_PC_LSB +: 8];
    assign rd_addr  = head[REC_ADDR_LSB +: 8];

    // fifo_full is implied by fifo_drop for overflow purposes but kept visible
    // for debug probing of the queue state.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_pmp_fault_unit.sv
// Directed bench for pmp_fault_unit: episode detection, priority, halt/resume,
// FIFO overflow and drain, counter clear and asynchronous reset.
module tb_pmp_fault_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pc_in, data_addr;
    logic       exec_v, read_v, write_v;
    logic       resume, clear_counts, rd_ready;
    logic       halt_req, rd_valid, overflow;
    logic [1:0] rd_cause;
    logic [7:0] rd_pc, rd_addr;
    logic [7:0] exec_count, read_count, write_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pmp_fault_unit #(.DEPTH(4), .CNT_W(8)) dut (
        .Clock                (clk),
        .Reset                (rst_n),
        .PC_In                (pc_in),
        .Data_Addr            (data_addr),
        .instr_exec_violation (exec_v),
        .data_read_violation  (read_v),
        .data_write_violation (write_v),
        .Resume               (resume),
        .Clear_Counts         (clear_counts),
        .Halt_Req             (halt_req),
        .rd_valid             (rd_valid),
        .rd_ready             (rd_ready),
        .rd_cause             (rd_cause),
        .rd_pc                (rd_pc),
        .rd_addr              (rd_addr),
        .exec_count           (exec_count),
        .read_count           (read_count),
        .write_count          (write_count),
        .Overflow             (overflow)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; pc_in = '0; data_addr = '0;
        exec_v = 0; read_v = 0; write_v = 0;
        resume = 0; clear_counts = 0; rd_ready = 0;
        #12;
        check_output("reset_halt", halt_req, 0);
        check_output("reset_valid", rd_valid, 0);
        check_output("reset_cause", rd_cause, 0);
        check_output("reset_exec_cnt", exec_count, 0);
        check_output("reset_ovf", overflow, 0);
        rst_n = 1'b1;
        tick(1);

        // Read held three cycles counts once
        pc_in = 8'h10; data_addr = 8'h80; read_v = 1;
        #1 check_output("t1_halt_comb", halt_req, 0);
        tick(3);
        read_v = 0;
        tick(1);
        check_output("t1_read_cnt", read_count, 1);
        check_output("t1_valid", rd_valid, 1);
        check_output("t1_cause", rd_cause, 2'b10);
        check_output("t1_pc", rd_pc, 8'h10);
        check_output("t1_addr", rd_addr, 8'h80);
        check_output("t1_halt", halt_req, 0);
        rd_ready = 1; tick(1); rd_ready = 0;
        check_output("t1_empty", rd_valid, 0);

        // Read then exec; exec freezes same cycle, write ignored while halted
        pc_in = 8'h20; data_addr = 8'h90; read_v = 1; tick(1); read_v = 0; tick(1);
        pc_in = 8'h24; data_addr = 8'h55; exec_v = 1;
        #1 check_output("t2_halt_comb", halt_req, 1);
        tick(1); exec_v = 0;
        check_output("t2_exec_cnt", exec_count, 1);
        tick(2);
        check_output("t2_halt_held", halt_req, 1);
        write_v = 1; tick(1); write_v = 0; tick(1);
        check_output("t2_write_cnt", write_count, 0);
        check_output("t2_head_cause", rd_cause, 2'b10);
        check_output("t2_head_pc", rd_pc, 8'h20);
        rd_ready = 1; tick(1);
        check_output("t2_rec2_cause", rd_cause, 2'b01);
        check_output("t2_rec2_pc", rd_pc, 8'h24);
        check_output("t2_rec2_addr", rd_addr, 8'h00);
        tick(1); rd_ready = 0;
        check_output("t2_empty", rd_valid, 0);
        resume = 1; tick(1); resume = 0;
        check_output("t2_resumed", halt_req, 0);

        // Exec and read together: only exec wins
        pc_in = 8'h30; data_addr = 8'h77; exec_v = 1; read_v = 1;
        tick(1); exec_v = 0; read_v = 0;
        check_output("t3_exec_cnt", exec_count, 2);
        check_output("t3_read_cnt", read_count, 2);
        check_output("t3_cause", rd_cause, 2'b01);
        check_output("t3_pc", rd_pc, 8'h30);
        check_output("t3_halt", halt_req, 1);
        rd_ready = 1; tick(1); rd_ready = 0;
        check_output("t3_single_rec", rd_valid, 0);
        resume = 1; tick(1); resume = 0;
        clear_counts = 1; tick(1); clear_counts = 0;
        check_output("t3_clr_exec", exec_count, 0);
        check_output("t3_clr_read", read_count, 0);

        // Five reads into a four-entry queue
        for (int i = 0; i < 5; i++) begin
            pc_in = 8'h50 + 8'(i); data_addr = 8'hA0 + 8'(i);
            read_v = 1; tick(1); read_v = 0; tick(1);
        end
        check_output("t4_read_cnt", read_count, 5);
        check_output("t4_ovf", overflow, 1);
        check_output("t4_halt", halt_req, 0);
        clear_counts = 1; tick(1); clear_counts = 0;
        check_output("t4_clr_ovf", overflow, 0);
        check_output("t4_clr_keeps_fifo", rd_pc, 8'h50);
        // Push and pop on a full queue both succeed
        pc_in = 8'h60; data_addr = 8'hB0; read_v = 1; rd_ready = 1;
        tick(1); read_v = 0; rd_ready = 0;
        check_output("t4_pushpop_ovf", overflow, 0);
        check_output("t4_pushpop_cnt", read_count, 1);
        for (int i = 0; i < 4; i++) begin
            check_output("t4_drain_cause", rd_cause, 2'b10);
            check_output("t4_drain_pc", rd_pc, (i == 3) ? 8'h60 : 8'h51 + 8'(i));
            check_output("t4_drain_addr", rd_addr, (i == 3) ? 8'hB0 : 8'hA1 + 8'(i));
            rd_ready = 1; tick(1); rd_ready = 0;
        end
        check_output("t4_drained", rd_valid, 0);

        // Halt, resume, re-halt; resume coinciding with exec stays halted
        pc_in = 8'h38; exec_v = 1; tick(1); exec_v = 0;
        check_output("t5_halt1", halt_req, 1);
        check_output("t5_exec_cnt1", exec_count, 1);
        resume = 1; tick(1); resume = 0;
        check_output("t5_released", halt_req, 0);
        pc_in = 8'h40; exec_v = 1;
        #1 check_output("t5_halt_comb", halt_req, 1);
        tick(1); exec_v = 0;
        check_output("t5_exec_cnt2", exec_count, 2);
        check_output("t5_halt2", halt_req, 1);
        tick(1);
        pc_in = 8'h44; exec_v = 1; resume = 1;
        tick(1); exec_v = 0; resume = 0;
        check_output("t5_res_exec_halt", halt_req, 1);
        check_output("t5_exec_cnt3", exec_count, 3);
        clear_counts = 1; tick(1); clear_counts = 0;
        check_output("t5_clr_exec", exec_count, 0);
        check_output("t5_clr_read", read_count, 0);
        check_output("t5_clr_halt", halt_req, 1);
        check_output("t5_clr_head", rd_pc, 8'h38);

        // Fill the queue while halted, then reset asynchronously
        resume = 1; tick(1); resume = 0;
        pc_in = 8'h48; exec_v = 1; tick(1); exec_v = 0;
        check_output("t6_exec_cnt", exec_count, 1);
        check_output("t6_halt", halt_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("t6_rst_halt", halt_req, 0);
        check_output("t6_rst_valid", rd_valid, 0);
        check_output("t6_rst_exec_cnt", exec_count, 0);
        check_output("t6_rst_pc", rd_pc, 0);
        rst_n = 1'b1;
        tick(2);
        check_output("t6_post_halt", halt_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
